// File: rtl/osiris_pkg.sv
// rtl/osiris_pkg.sv - shared constants for the osiris fetch/decode front end
package osiris_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_STEP   = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// rtl/fetch_queue_mem.sv - fetch queue entry storage, one sync write port, one async read port
// Data is intentionally not reset; validity is tracked by the controller's count.
module fetch_queue_mem #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - IF/ID instruction queue with flush; OSIRIS_FETCH_BYPASS_EN enables
// same-cycle forwarding of an incoming instruction into an empty queue.
module fetch_queue
  import osiris_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_IF,
  output logic             o_ready_IF,
  input  logic [WIDTH-1:0] i_instr_IF,
  input  logic [WIDTH-1:0] i_pc_IF,
  input  logic             i_flush,
  input  logic             i_stall_ID,
  output logic             o_valid_ID,
  output logic [WIDTH-1:0] o_instr_ID,
  output logic [WIDTH-1:0] o_pc_ID,
  output logic [WIDTH-1:0] o_pc_plus4_ID,
  output logic [WIDTH-8:0] o_imm_ID
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               empty;
  logic               full;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               mem_we;
  logic               mem_pop;
  logic [2*WIDTH-1:0] rd_data;
  logic [WIDTH-1:0]   head_instr;
  logic [WIDTH-1:0]   head_pc;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready depends only on registered occupancy, never on the decode stall.
  assign o_ready_IF = ~i_rst & ~full;
  assign push       = i_valid_IF & o_ready_IF;

`ifdef OSIRIS_FETCH_BYPASS_EN
  assign bypass = empty & i_valid_IF & ~i_flush & ~i_rst;
`else
  assign bypass = 1'b0;
`endif

  assign o_valid_ID = (~empty & ~i_flush & ~i_rst) | bypass;
  assign pop        = o_valid_ID & ~i_stall_ID;

  // A bypassed entry consumed this cycle never touches storage.
  assign mem_we  = push & ~i_flush & ~(bypass & ~i_stall_ID);
  assign mem_pop = pop & ~empty;

  fetch_queue_mem #(
    .WIDTH  (2 * WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_waddr (wr_ptr),
    .i_wdata ({i_instr_IF, i_pc_IF}),
    .i_raddr (rd_ptr),
    .o_rdata (rd_data)
  );

  assign head_instr = rd_data[2*WIDTH-1:WIDTH];
  assign head_pc    = rd_data[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (mem_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({mem_we, mem_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    o_instr_ID = WIDTH'(NOP_INSTR);
    o_pc_ID    = '0;
    if (bypass) begin
      o_instr_ID = i_instr_IF;
      o_pc_ID    = i_pc_IF;
    end else if (o_valid_ID) begin
      o_instr_ID = head_instr;
      o_pc_ID    = head_pc;
    end
  end

  assign o_pc_plus4_ID = o_pc_ID + WIDTH'(PC_STEP);
  assign o_imm_ID      = o_instr_ID[WIDTH-1:7];

endmodule
